hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding controller for the pipelined CPU. It tracks in-flight register writers in a shift-register scoreboard spanning DEPTH post-decode stages and generates the ID stall. It also produces the forwarding selects for branch operands in ID and registered selects for ALU operands in EX. It replaces the fixed EX/MEM/WB compare logic with configurable depth, configurable load/ALU result latency, a pipeline-freeze input, a full flush and a stall performance counter.

---
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight register-writer scoreboard for the pipelined CPU.
// Tracks writers in DEPTH post-decode stages (entry 1 = EX), stalls ID when
// a source operand would not be ready in time, and produces forwarding selects.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   id_*                  decoded ID-stage instruction (valid, write, load, dst,
//                         branch, sources and their use flags)
//   freeze                hold the whole scoreboard
//   flush_all             invalidate every tracked entry
//   stall                 hold PC and IF/ID, bubble into EX (combinational)
//   fwd_a_id, fwd_b_id    branch-operand selects in ID (combinational)
//   fwd_a_ex, fwd_b_ex    ALU-operand selects for the instruction in EX (registered)
//   stall_cnt             saturating count of stall cycles
module hazard_scoreboard #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_RDY  = 2,
    parameter int unsigned LOAD_RDY = 3,
    parameter int unsigned SEL_W    = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_we,
    input  logic              id_load,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              freeze,
    input  logic              flush_all,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_id,
    output logic [SEL_W-1:0]  fwd_b_id,
    output logic [SEL_W-1:0]  fwd_a_ex,
    output logic [SEL_W-1:0]  fwd_b_ex,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH:1]    v_q;
    logic [DEPTH:1]    load_q;
    logic [REG_AW-1:0] dst_q [1:DEPTH];

    // Index 0 = source A, index 1 = source B.
    logic [REG_AW-1:0] src    [2];
    logic              rd     [2];
    logic              hit    [2];
    int                hit_j  [2];
    int                need   [2];
    logic              haz    [2];
    logic [SEL_W-1:0]  sel_id [2];
    logic [SEL_W-1:0]  sel_ex [2];

    assign src[0] = id_src_a;
    assign src[1] = id_src_b;
    assign rd[0]  = id_use_a;
    assign rd[1]  = id_use_b;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]    = 1'b0;
            hit_j[s]  = 0;
            need[s]   = int'(ALU_RDY);
            haz[s]    = 1'b0;
            sel_id[s] = '0;
            sel_ex[s] = '0;
            // Scan oldest to youngest so the youngest producer wins.
            for (int j = int'(DEPTH); j >= 1; j--) begin
                if (v_q[j] && rd[s] && (dst_q[j] == src[s])) begin
                    hit[s]   = 1'b1;
                    hit_j[s] = j;
                    need[s]  = load_q[j] ? int'(LOAD_RDY) : int'(ALU_RDY);
                end
            end
            if (hit[s]) begin
                if (id_branch) begin
                    if (hit_j[s] >= need[s]) sel_id[s] = SEL_W'(hit_j[s]);
                    else                     haz[s]    = 1'b1;
                end else begin
                    // Producer moves one stage on before the consumer reaches EX;
                    // past the last stage it is already in the register file.
                    if (hit_j[s] + 1 > int'(DEPTH))   sel_ex[s] = '0;
                    else if (hit_j[s] + 1 >= need[s]) sel_ex[s] = SEL_W'(hit_j[s] + 1);
                    else                              haz[s]    = 1'b1;
                end
            end
        end
    end

    assign stall    = id_valid && (haz[0] || haz[1]);
    assign fwd_a_id = sel_id[0];
    assign fwd_b_id = sel_id[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= '0;
            load_q   <= '0;
            for (int j = 1; j <= int'(DEPTH); j++) dst_q[j] <= '0;
            fwd_a_ex <= '0;
            fwd_b_ex <= '0;
        end else if (flush_all) begin
            v_q      <= '0;
            fwd_a_ex <= '0;
            fwd_b_ex <= '0;
        end else if (!freeze) begin
            for (int j = int'(DEPTH); j >= 2; j--) begin
                v_q[j]    <= v_q[j-1];
                load_q[j] <= load_q[j-1];
                dst_q[j]  <= dst_q[j-1];
            end
            v_q[1]    <= id_valid && !stall && id_we && (id_dst != '0);
            load_q[1] <= id_load;
            dst_q[1]  <= id_dst;
            fwd_a_ex  <= stall ? '0 : sel_ex[0];
            fwd_b_ex  <= stall ? '0 : sel_ex[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && !freeze && !flush_all && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model
// in which each producer's stage is derived from its issue time.
module tb_hazard_scoreboard;

    localparam int DEPTH    = 3;
    localparam int ALU_RDY  = 2;
    localparam int LOAD_RDY = 3;
    localparam int CNT_MAX  = 65535;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0, id_we = 1'b0, id_load = 1'b0, id_branch = 1'b0;
    logic [4:0] id_dst = '0, id_src_a = '0, id_src_b = '0;
    logic       id_use_a = 1'b0, id_use_b = 1'b0;
    logic       freeze = 1'b0, flush_all = 1'b0;
    logic        stall;
    logic [1:0]  fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex;
    logic [15:0] stall_cnt;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_we     (id_we),
        .id_load   (id_load),
        .id_dst    (id_dst),
        .id_branch (id_branch),
        .id_src_a  (id_src_a),
        .id_src_b  (id_src_b),
        .id_use_a  (id_use_a),
        .id_use_b  (id_use_b),
        .freeze    (freeze),
        .flush_all (flush_all),
        .stall     (stall),
        .fwd_a_id  (fwd_a_id),
        .fwd_b_id  (fwd_b_id),
        .fwd_a_ex  (fwd_a_ex),
        .fwd_b_ex  (fwd_b_ex),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writers in issue order, stage = adv - born + 1.
    typedef struct {
        int dst;
        bit load;
        int born;
    } rec_t;

    rec_t q[$];
    int   adv = 0;
    int   m_ex_a = 0, m_ex_b = 0, m_cnt = 0;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        adv    = 0;
        m_ex_a = 0;
        m_ex_b = 0;
        m_cnt  = 0;
    endtask

    function automatic void predict(input int src, input bit used, output bit haz,
                                    output int fid, output int fex);
        haz = 1'b0;
        fid = 0;
        fex = 0;
        if (used) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].dst == src) begin
                    int stage;
                    int req;
                    stage = adv - q[i].born + 1;
                    req   = q[i].load ? LOAD_RDY : ALU_RDY;
                    if (id_branch) begin
                        if (stage >= req) fid = stage;
                        else              haz = 1'b1;
                    end else begin
                        if (stage + 1 > DEPTH)     fex = 0;
                        else if (stage + 1 >= req) fex = stage + 1;
                        else                       haz = 1'b1;
                    end
                    break;
                end
            end
        end
    endfunction

    // Compare every DUT output against the model, away from the clock edge.
    task automatic settle();
        bit ha, hb, st;
        int fia, fib, fea, feb;
        @(negedge clk);
        predict(int'(id_src_a), id_use_a, ha, fia, fea);
        predict(int'(id_src_b), id_use_b, hb, fib, feb);
        st = id_valid && (ha || hb);
        chk("stall", 32'(stall), 32'(st));
        chk("fwd_a_id", 32'(fwd_a_id), 32'(fia));
        chk("fwd_b_id", 32'(fwd_b_id), 32'(fib));
        chk("fwd_a_ex", 32'(fwd_a_ex), 32'(m_ex_a));
        chk("fwd_b_ex", 32'(fwd_b_ex), 32'(m_ex_b));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic advance();
        bit   ha, hb, st;
        int   fia, fib, fea, feb;
        rec_t r;
        predict(int'(id_src_a), id_use_a, ha, fia, fea);
        predict(int'(id_src_b), id_use_b, hb, fib, feb);
        st = id_valid && (ha || hb);
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (st && !freeze && !flush_all && m_cnt < CNT_MAX) m_cnt++;
            if (flush_all) begin
                q.delete();
                m_ex_a = 0;
                m_ex_b = 0;
            end else if (!freeze) begin
                adv++;
                while (q.size() > 0 && (adv - q[0].born + 1) > DEPTH) void'(q.pop_front());
                if (id_valid && !st && id_we && id_dst != 0) begin
                    r.dst  = int'(id_dst);
                    r.load = id_load;
                    r.born = adv;
                    q.push_back(r);
                end
                m_ex_a = st ? 0 : fea;
                m_ex_b = st ? 0 : feb;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit we, input bit ld, input int dst, input bit br,
                         input int sa, input bit ua, input int sb, input bit ub);
        id_valid  = v;
        id_we     = we;
        id_load   = ld;
        id_dst    = 5'(dst);
        id_branch = br;
        id_src_a  = 5'(sa);
        id_use_a  = ua;
        id_src_b  = 5'(sb);
        id_use_b  = ub;
        freeze    = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            advance();
        end
    endtask

    initial begin
        #12;
        chk("reset stall", 32'(stall), 0);
        chk("reset fwd_a_ex", 32'(fwd_a_ex), 0);
        chk("reset fwd_b_ex", 32'(fwd_b_ex), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ALU write r3, dependent ALU op on B forwards from stage 2.
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 0, 0, 3, 1); settle(); chk("alu-alu stall", 32'(stall), 0); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("alu-alu fwd_b_ex", 32'(fwd_b_ex), 2);
        advance(); idle(3);

        // Load r5, dependent ALU op on A: one stall, then stage 3 forward.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); settle(); chk("load-use stall", 32'(stall), 1); advance();
        settle(); chk("load-use release", 32'(stall), 0); chk("load-use cnt", 32'(stall_cnt), 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("load-use fwd_a_ex", 32'(fwd_a_ex), 3);
        advance(); idle(3);

        // ALU r7 then beq r7: one stall, then fwd_a_id = 2.
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 1, 7, 1, 0, 0); settle(); chk("alu-br stall", 32'(stall), 1); advance();
        settle(); chk("alu-br release", 32'(stall), 0); chk("alu-br fwd_a_id", 32'(fwd_a_id), 2);
        advance(); idle(3);

        // Load r7 then beq r7: two stalls, then fwd_a_id = 3.
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 1, 7, 1, 0, 0); settle(); chk("ld-br stall1", 32'(stall), 1); advance();
        settle(); chk("ld-br stall2", 32'(stall), 1); advance();
        settle(); chk("ld-br release", 32'(stall), 0); chk("ld-br fwd_a_id", 32'(fwd_a_id), 3);
        chk("ld-br cnt", 32'(stall_cnt), 4);
        advance(); idle(3);

        // r0 writers and unused sources never create hazards.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1); settle(); chk("r0 stall", 32'(stall), 0); advance();
        drive(1, 1, 1, 6, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 1, 6, 0, 6, 0); settle(); chk("unused stall", 32'(stall), 0);
        chk("unused fwd_a_id", 32'(fwd_a_id), 0); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("r0 fwd_a_ex", 32'(fwd_a_ex), 0);
        advance(); idle(3);

        // Two writers of r2: the youngest (stage 1) wins.
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0); settle(); chk("youngest stall", 32'(stall), 0); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("youngest fwd_a_ex", 32'(fwd_a_ex), 2);
        advance(); idle(3);

        // Load-use stall held by freeze, then cleared by flush.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("freeze stall", 32'(stall), 1); chk("freeze cnt", 32'(stall_cnt), 4);
            advance();
        end
        freeze = 1'b0;
        flush_all = 1'b1;
        settle(); chk("pre-flush stall", 32'(stall), 1); advance();
        flush_all = 1'b0;
        settle(); chk("flush stall", 32'(stall), 0); chk("flush fwd_a_ex", 32'(fwd_a_ex), 0);
        chk("flush fwd_a_id", 32'(fwd_a_id), 0); chk("flush cnt", 32'(stall_cnt), 4);
        advance(); idle(3);

        // Asynchronous reset mid-stall clears everything at once.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); settle(); chk("pre-reset stall", 32'(stall), 1);
        reset = 1'b0;
        #1;
        chk("async reset stall", 32'(stall), 0);
        chk("async reset cnt", 32'(stall_cnt), 0);
        model_clear();
        advance();
        reset = 1'b1;
        idle(2);

        // Randomized traffic over a small register set to provoke dependencies.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            freeze    = ($urandom_range(0, 9) == 0);
            flush_all = ($urandom_range(0, 29) == 0);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
